sipo: RTL and testbench

- Serial-in/parallel-out word assembler. Accepts DATA_WIDTH-bit words, one per qualified clock, and packs NUM_WORDS of them into a single wide word.
- Defaults: 8 bytes in, 64-bit word out.
- Sits between a byte-wide stream source and a 64-bit datapath consumer.
- Signals a completed frame with a one-cycle done pulse.

---
 rtl/sipo.sv | 58 +++++
 tb/tb_sipo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// Serial-in/parallel-out word assembler.
// Packs NUM_WORDS serial words of DATA_WIDTH bits into one OUT_WIDTH-bit
// frame. The first word accepted ends up in the MSBs of the frame. A one-cycle
// done pulse marks each completed frame.
module sipo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_WORDS  = 8,
  localparam int OUT_WIDTH  = DATA_WIDTH * NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] serial_in,
  output logic [OUT_WIDTH-1:0]  parallel_out,
  output logic                  done
);

  localparam int SH_W  = OUT_WIDTH - DATA_WIDTH;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  logic [SH_W-1:0]      shreg;
  logic [CNT_W-1:0]     count;
  logic [OUT_WIDTH-1:0] frame;

  // Stored partial words with the incoming word appended at the LSBs.
  // The low SH_W bits of this are the next shift-register value, and the full
  // width is the completed frame. Slicing it this way also covers NUM_WORDS=2.
  always_comb begin
    frame = {shreg, serial_in};
  end

  // Word counter, shift register, frame output and done pulse.
  // Reset takes priority over ready. When ready is low, nothing is sampled
  // from serial_in, so an undefined serial_in cannot disturb the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg        <= '0;
      count        <= '0;
      parallel_out <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ready) begin
        if (count == LAST) begin
          parallel_out <= frame;
          done         <= 1'b1;
          count        <= '0;
          shreg        <= '0;
        end else begin
          shreg <= frame[SH_W-1:0];
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo.sv
// Testbench for sipo. Stimulus pushes the expected frames into a scoreboard
// queue. A monitor process checks done and parallel_out after every clock edge.
module tb_sipo;

  localparam int DW = 8;
  localparam int NW = 8;
  localparam int OW = DW * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic [DW-1:0] serial_in;
  logic [OW-1:0] parallel_out;
  logic          done;

  typedef struct {
    logic [OW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] exp_hold = '0;

  sipo #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    logic rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = rst;
      #1;
      if (!rst_s) begin
        exp_hold = '0;
        checks++;
        if (done !== 1'b0 || parallel_out !== '0) begin
          errors++;
          $display("FAIL reset cyc=%0d: done=%b out=%h, required done=0 out=0", cyc, done, parallel_out);
        end
      end else if (done === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d: out=%h, required no done", cyc, parallel_out);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || parallel_out !== e.data) begin
            errors++;
            $display("FAIL frame cyc=%0d: out=%h, required out=%h at cyc=%0d", cyc, parallel_out, e.data, e.cyc);
          end
          exp_hold = e.data;
        end
      end else begin
        checks++;
        if (done !== 1'b0 || parallel_out !== exp_hold) begin
          errors++;
          $display("FAIL hold cyc=%0d: done=%b out=%h, required done=0 out=%h", cyc, done, parallel_out, exp_hold);
        end
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          errors++;
          e = q.pop_front();
          $display("FAIL missed_done cyc=%0d: no done, required done with out=%h", cyc, e.data);
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] b);
    @(negedge clk);
    rst       = 1'b1;
    ready     = 1'b1;
    serial_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b1;
      ready     = 1'b0;
      serial_in = 'x;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      ready     = 1'b1;
      serial_in = 8'hAA;
    end
  endtask

  // The last byte was just driven, so the frame must appear on the next edge.
  task automatic expect_frame(input logic [OW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  // Stimulus.
  initial begin : stim
    logic [DW-1:0] rb[NW];
    rst       = 1'b0;
    ready     = 1'b0;
    serial_in = '0;
    do_reset(2);

    // Bytes 01..08, then idle.
    for (int i = 1; i <= 8; i++) send(DW'(i));
    expect_frame(64'h0102030405060708);
    idle(4);

    // Partial frame discarded by reset.
    send(8'hF0); send(8'hF1); send(8'hF2); send(8'hF3);
    do_reset(1);
    for (int i = 0; i < 8; i++) send(DW'(8'h11 + i));
    expect_frame(64'h1112131415161718);
    idle(2);

    // Random bytes with a 3-cycle gap between b3 and b4.
    for (int i = 0; i < NW; i++) rb[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) send(rb[i]);
    idle(3);
    for (int i = 4; i < 8; i++) send(rb[i]);
    expect_frame({rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], rb[6], rb[7]});
    idle(2);

    // Back-to-back frames.
    for (int i = 0; i < 8; i++) send(DW'(i));
    expect_frame(64'h0001020304050607);
    for (int i = 8; i < 16; i++) send(DW'(i));
    expect_frame(64'h08090A0B0C0D0E0F);

    // Partial frame after a completed one: output holds, no done.
    send(8'h55); send(8'h66); send(8'h77);
    idle(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d frames outstanding, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
